// File: rtl/fti_seq.sv
// fti_seq: sequential IEEE-754 single-precision to unsigned integer converter.
// Special and trivial inputs resolve straight away. In-range values rebuild the
// integer one mantissa bit per cycle, starting from the hidden bit.
// The result is truncated toward zero, saturated to 255 on overflow, and
// returned with one status flag or none.
//
// Handshake: a transfer happens on a rising clk edge when valid and ready are
// both high. in_ready is high only in IDLE. While out_valid is high, out_data
// and the flags stay stable until out_ready is seen high on an edge.
module fti_seq #(
    parameter int BIAS  = 127,
    parameter int OUT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_ovf,
    output logic             out_neg,
    output logic             out_nan,
    output logic [1:0]       dbg_state
);

    localparam int         CW     = $clog2(OUT_W);
    localparam logic [7:0] L_BIAS = 8'(BIAS);
    localparam logic [7:0] L_EMAX = 8'(BIAS + OUT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_next_state;

    logic [OUT_W-1:0]  r_acc;
    logic [22:0]       r_sreg;
    logic [CW-1:0]     r_cnt;
    logic              r_ovf;
    logic              r_neg;
    logic              r_nan;

    logic              w_in_ready;
    logic              w_accept;
    logic              w_sign;
    logic [7:0]        w_exp;
    logic [22:0]       w_man;
    logic [7:0]        w_exp_off;
    logic              w_shift;
    logic [OUT_W-1:0]  w_ld_data;
    logic              w_ld_ovf;
    logic              w_ld_neg;
    logic              w_ld_nan;

    assign w_sign    = in_data[31];
    assign w_exp     = in_data[30:23];
    assign w_man     = in_data[22:0];
    assign w_exp_off = w_exp - L_BIAS;
    assign w_accept  = in_valid && w_in_ready;

    // Classify the input in priority order: NaN, negative, tiny, overflow, one, shift.
    always_comb begin
        w_shift   = 1'b0;
        w_ld_data = '0;
        w_ld_ovf  = 1'b0;
        w_ld_neg  = 1'b0;
        w_ld_nan  = 1'b0;
        if (w_exp == 8'hFF && w_man != 23'd0) begin
            w_ld_nan = 1'b1;
        end else if (w_sign) begin
            // Magnitude >= 1.0 clamps with a flag; smaller negatives truncate to 0.
            w_ld_neg = (w_exp >= L_BIAS);
        end else if (w_exp < L_BIAS) begin
            w_ld_data = '0;
        end else if (w_exp > L_EMAX) begin
            w_ld_data = '1;
            w_ld_ovf  = 1'b1;
        end else if (w_exp == L_BIAS) begin
            w_ld_data = OUT_W'(1);
        end else begin
            w_shift = 1'b1;
        end
    end

    // State register; reset aborts any conversion in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        w_in_ready   = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = !rst;
                if (w_accept) begin
                    w_next_state = w_shift ? S_SHIFT : S_DONE;
                end
            end
            S_SHIFT: begin
                if (r_cnt == CW'(1)) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Datapath: load on accept, shift one mantissa bit per SHIFT cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc  <= '0;
            r_sreg <= '0;
            r_cnt  <= '0;
            r_ovf  <= 1'b0;
            r_neg  <= 1'b0;
            r_nan  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sreg <= w_man;
                        if (w_shift) begin
                            // Hidden bit first; exponent offset counts the remaining bits.
                            r_acc <= OUT_W'(1);
                            r_cnt <= w_exp_off[CW-1:0];
                        end else begin
                            r_acc <= w_ld_data;
                            r_cnt <= '0;
                            r_ovf <= w_ld_ovf;
                            r_neg <= w_ld_neg;
                            r_nan <= w_ld_nan;
                        end
                    end
                end
                S_SHIFT: begin
                    r_acc  <= {r_acc[OUT_W-2:0], r_sreg[22]};
                    r_sreg <= {r_sreg[21:0], 1'b0};
                    r_cnt  <= r_cnt - CW'(1);
                    // A shifted result is always in range, so it carries no flag.
                    if (r_cnt == CW'(1)) begin
                        r_ovf <= 1'b0;
                        r_neg <= 1'b0;
                        r_nan <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = w_in_ready;
    assign out_data  = r_acc;
    assign out_ovf   = r_ovf;
    assign out_neg   = r_neg;
    assign out_nan   = r_nan;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fti_seq.sv
// Bench for fti_seq: directed cases, backpressure, reset abort, an exhaustive
// int->float->int round trip and random floats, all against a value-level model.
module tb_fti_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_ovf;
    logic        out_neg;
    logic        out_nan;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {ovf, neg, nan, data} per accepted input, in order.
    logic [10:0] exp_q[$];

    fti_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_neg   (out_neg),
        .out_nan   (out_nan),
        .dbg_state (dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Watchdog
    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: real-valued truncation of the float, with the classification rules.
    task automatic ref_model(input logic [31:0] f, output logic [7:0] d,
                             output logic [2:0] fl, output int lat);
        int unsigned e;
        longint unsigned m;
        e   = f[30:23];
        m   = f[22:0];
        d   = 8'd0;
        fl  = 3'b000;
        lat = 1;
        if (e == 255 && m != 0) begin
            fl = 3'b001;
        end else if (f[31]) begin
            if (e >= 127) fl = 3'b010;
        end else if (e < 127) begin
            d = 8'd0;
        end else if (e > 134) begin
            d  = 8'd255;
            fl = 3'b100;
        end else begin
            d = 8'(((64'd1 << 23) + m) >> (150 - e));
            if (e > 127) lat = int'(e) - 126;
        end
    endtask

    // The combinational int-to-float mapping for an 8-bit unsigned value.
    function automatic logic [31:0] i2f(input int n);
        int p;
        int m;
        if (n == 0) return 32'h0;
        p = 0;
        for (int i = 0; i < 8; i++) if (n >= (1 << i)) p = i;
        m = (n - (1 << p)) << (23 - p);
        return {1'b0, 8'(127 + p), 23'(m)};
    endfunction

    // Drive one float, check latency, result, hold stability and the out handshake.
    task automatic run_one(input logic [31:0] f, input int pre_gap, input int hold);
        logic [7:0]  ed;
        logic [2:0]  ef;
        logic [10:0] exp_v;
        int          elat;
        int          lat;
        int          t;
        string       tg;
        ref_model(f, ed, ef, elat);
        exp_q.push_back({ef, ed});
        tg = $sformatf("%08h", f);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (pre_gap) @(negedge clk);
        in_data  = f;
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) check({tg, " accept_timeout"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        exp_v = exp_q.pop_front();
        check({tg, " latency"}, 32'(lat), 32'(elat));
        check({tg, " data"}, 32'(out_data), 32'(exp_v[7:0]));
        check({tg, " flags"}, {29'd0, out_ovf, out_neg, out_nan}, 32'(exp_v[10:8]));
        for (int k = 0; k < hold; k++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = $urandom;
            @(posedge clk);
            #1;
            check({tg, " hold"}, {21'd0, out_valid, in_ready, out_ovf, out_neg, out_nan, out_data},
                  {21'd0, 1'b1, 1'b0, exp_v});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tg, " release"}, {30'd0, out_valid, in_ready}, 32'b01);
    endtask

    // Stimulus and report
    initial begin
        logic [31:0] dir_tab[14];
        logic [31:0] f;
        dir_tab = '{32'h43000000, 32'h3F800000, 32'h437FE666, 32'h3F400000, 32'h40E00000,
                    32'h43800000, 32'h7F800000, 32'h7FC00000, 32'hC0400000, 32'h80000000,
                    32'hFF800000, 32'hBF000000, 32'h00000001, 32'h42FF0000};
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_data   = 32'h0;
        repeat (3) @(negedge clk);
        check("reset_outputs", {20'd0, in_ready, out_valid, out_ovf, out_neg, out_nan, out_data}, 32'd0);
        rst = 1'b0;
        #1;
        check("reset_release_ready", 32'(in_ready), 32'd1);

        foreach (dir_tab[i]) run_one(dir_tab[i], 0, 1);

        // Backpressure with junk in_valid pulses while busy.
        run_one(32'h43000000, 1, 5);
        run_one(32'h40E00000, 0, 5);

        // Reset in the middle of a shift.
        @(negedge clk);
        in_data  = 32'h43000000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_outputs", {20'd0, in_ready, out_valid, out_ovf, out_neg, out_nan, out_data}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_release_ready", {30'd0, in_ready, out_valid}, 32'b10);
        run_one(32'h42C80000, 0, 0);

        // Exhaustive round trip with random gaps.
        for (int n = 0; n < 256; n++) begin
            run_one(i2f(n), $urandom_range(0, 3), $urandom_range(0, 3));
        end

        // Random floats, concentrated around the interesting exponents.
        for (int r = 0; r < 150; r++) begin
            f = $urandom;
            if (r % 3 != 0) begin
                f[30:23] = 8'($urandom_range(120, 140));
                f[31]    = ($urandom_range(0, 3) == 0);
            end
            run_one(f, $urandom_range(0, 2), $urandom_range(0, 2));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fti_seq.md
Name: fti_seq

Overview:
Sequential IEEE-754 single-precision to 8-bit unsigned integer converter. It is the inverse of the existing combinational int-to-float block.
- Takes a 32-bit float through a valid/ready handshake.
- Reconstructs the integer by shifting mantissa bits into an accumulator, one bit per cycle.
- Returns the truncated (round-toward-zero) result with saturation and status flags.
- Sits at the float-datapath output, feeding 8-bit integer consumers.

Parameters:
BIAS, 127, exponent bias; fixed to the IEEE-754 single-precision value, not intended to be changed.
OUT_W, 8, output integer width; the maximum in-range exponent is BIAS+OUT_W-1 = 134.

Ports:
clk  input  1  single clock, rising edge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  in_data is valid.
in_ready  output  1  block can accept an input (high only in IDLE).
in_data  input  32  IEEE-754 single: [31] sign, [30:23] exponent, [22:0] mantissa.
out_valid  output  1  out_data and flags are valid.
out_ready  input  1  consumer accepts the result.
out_data  output  8  unsigned integer result.
out_ovf  output  1  magnitude >= 256 or +Inf; result saturated to 255.
out_neg  output  1  negative input with magnitude >= 1.0; result clamped to 0.
out_nan  output  1  input was NaN; result 0.

Behaviour:
- Reset (async, rst=1): state=IDLE; in_ready=0 while rst asserted, 1 after release; out_valid=0; out_data=0; all flags 0; accumulator and counter 0.
- Reset asserted mid-operation aborts the conversion immediately. No output is produced for the aborted input.
- States: IDLE, SHIFT, DONE.
- IDLE: in_ready=1. Accept on rising edge with in_valid=1. Decode e=in_data[30:23], m=in_data[22:0], s=in_data[31], then classify in priority order:
  - e=255, m!=0: NaN -> DONE, data 0, nan=1.
  - s=1, e>=127 (includes -Inf): DONE, data 0, neg=1.
  - s=1, e<127: DONE, data 0, no flag. Covers -0.0, negative denormals and -1.0<x<0.
  - e<127 (zero, denormal, 0<x<1): DONE, data 0.
  - e>134 (includes +Inf): DONE, data 255, ovf=1.
  - e=127 (1.0<=x<2.0): DONE, data 1.
  - 128<=e<=134: SHIFT. Load acc=1 (hidden bit), sreg=m, cnt=e-127 (range 1..7).
- SHIFT: each cycle:
  - acc <= {acc[6:0], sreg[22]};
  - sreg <= sreg<<1;
  - cnt <= cnt-1.
  - When cnt==1 on a cycle, go to DONE on the next edge with out_data = the shifted acc.
  - Lower mantissa bits are discarded (truncation); no rounding.
- DONE: out_valid=1. out_data and flags stay stable until out_ready=1 on an edge, then go to IDLE with out_valid=0. Flags hold their value from the last result until the next result is loaded.
- Latency, accept edge to the first cycle of out_valid:
  - 1 cycle for special/trivial cases.
  - 1+(e-127) cycles for e in 128..134; maximum 8 (e=134).
- Throughput: no overlap. in_ready=0 during SHIFT and DONE. The next accept is possible the cycle after the out handshake.
- in_data is ignored when not accepted. in_valid may drop or change freely while in_ready=0.
- Exactly one flag is set per result, or none. out_data is never X after reset.

Test Plan:
- 0x43000000 (128.0) accepted in IDLE -> out_data=128, flags 0, out_valid first high 8 cycles after accept; 0x3F800000 (1.0) -> 1 after 1 cycle.
- 0x437FE666 (~255.9) -> 255, ovf=0 (truncation); 0x3F400000 (0.75) -> 0, no flags; 0x40E00000 (7.0) -> 7, latency 3.
- 0x43800000 (256.0) and 0x7F800000 (+Inf) -> 255, ovf=1, latency 1; 0x7FC00000 (NaN) -> 0, nan=1; 0xC0400000 (-3.0) -> 0, neg=1; 0x80000000 (-0.0) -> 0, no flags.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_data/flags stable, in_ready=0, new in_valid pulses ignored; raise out_ready -> IDLE next cycle, next input accepted.
- Reset mid-SHIFT: assert rst 3 cycles after accepting 0x43000000 -> out_valid=0, out_data=0 immediately; after release, 0x42C80000 (100.0) -> 100.
- Round trip, exhaustive: for n=0..255, feed the int-to-float block's output for n -> out_data==n, flags 0, with randomized in_valid/out_ready gaps.
